// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared instruction codes, load length and feeder encodings
package npu_pkg;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    // Number of key-load slots per run; the chain holds at most this many columns.
    localparam int LOAD_LEN = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CRST  = 3'd1,
        ST_KLOAD = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } feed_state_e;

    // Which SRAM (if any) supplies the data word of a slot.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_K    = 2'd1,
        SRC_Q    = 2'd2
    } feed_src_e;

endpackage

// File: rtl/feed_pipe.sv
// rtl/feed_pipe.sv - 2-stage slot pipe aligning instruction with 1-cycle SRAM read data
module feed_pipe
    import npu_pkg::*;
#(
    parameter int bw = 8,
    parameter int pr = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       inst_i,
    input  feed_src_e        src_i,
    input  logic [pr*bw-1:0] k_rdata_i,
    input  logic [pr*bw-1:0] q_rdata_i,
    output logic [1:0]       inst_o,
    output logic [pr*bw-1:0] data_o
);

    logic [1:0]       inst_s1_q;
    feed_src_e        src_s1_q;
    logic             vld_s1_q;
    logic [1:0]       inst_s2_q;
    logic [pr*bw-1:0] data_q;
    logic [pr*bw-1:0] data_d;

    // Stage 1: remember the slot while the SRAM read is in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            inst_s1_q <= INST_IDLE;
            src_s1_q  <= SRC_ZERO;
            vld_s1_q  <= 1'b0;
        end else begin
            inst_s1_q <= inst_i;
            src_s1_q  <= src_i;
            vld_s1_q  <= (inst_i != INST_IDLE);
        end
    end

    // Pick the returned SRAM word for valid slots; hold the data word on idle slots.
    always_comb begin
        data_d = data_q;
        if (vld_s1_q) begin
            case (src_s1_q)
                SRC_K:   data_d = k_rdata_i;
                SRC_Q:   data_d = q_rdata_i;
                default: data_d = '0;
            endcase
        end
    end

    // Stage 2: present instruction and data together to column 0.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            inst_s2_q <= INST_IDLE;
            data_q    <= '0;
        end else begin
            inst_s2_q <= inst_s1_q;
            data_q    <= data_d;
        end
    end

    assign inst_o = inst_s2_q;
    assign data_o = data_q;

endmodule

// File: rtl/mac_col_feeder.sv
// rtl/mac_col_feeder.sv - column-chain head feeder: col reset, K load, Q execute, drain; MAC_FEED_BP_EN adds ofifo_full stalls
module mac_col_feeder
    import npu_pkg::*;
#(
    parameter int bw  = 8,
    parameter int pr  = 8,
    parameter int col = 8,
    parameter int aw  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [aw-1:0]    num_q,
    output logic             busy,
    output logic             done,
    output logic             col_reset,
    output logic             k_cen,
    output logic [aw-1:0]    k_addr,
    input  logic [pr*bw-1:0] k_rdata,
    output logic             q_cen,
    output logic [aw-1:0]    q_addr,
    input  logic [pr*bw-1:0] q_rdata,
    output logic [1:0]       o_inst,
    output logic [pr*bw-1:0] q_out
`ifdef MAC_FEED_BP_EN
    ,
    input  logic             ofifo_full
`endif
);

    // Counter must reach LOAD_LEN-1, col+2 and num_q-1.
    localparam int CW = (aw > 4) ? aw : 4;

    feed_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [aw-1:0] nq_q, nq_d;
    logic [1:0]    inst;
    feed_src_e     src;
    logic          stall;

`ifdef MAC_FEED_BP_EN
    assign stall = ofifo_full;
`else
    assign stall = 1'b0;
`endif

    // State, slot counter and latched Q count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            nq_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nq_q    <= nq_d;
        end
    end

    // Next state plus SRAM strobes and the slot issued into the pipe this cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nq_d      = nq_q;
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;
        col_reset = 1'b0;
        k_cen     = 1'b1;
        k_addr    = '0;
        q_cen     = 1'b1;
        q_addr    = '0;
        inst      = INST_IDLE;
        src       = SRC_ZERO;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nq_d    = num_q;
                    cnt_d   = '0;
                    state_d = ST_CRST;
                end
            end
            ST_CRST: begin
                col_reset = 1'b1;
                cnt_d     = '0;
                state_d   = ST_KLOAD;
            end
            ST_KLOAD: begin
                // Slot k carries the key of column 9-k; early slots fall off the end of a short chain.
                inst = INST_LOAD;
                if (cnt_q >= CW'(LOAD_LEN - col)) begin
                    k_cen  = 1'b0;
                    k_addr = aw'(LOAD_LEN - 1) - aw'(cnt_q);
                    src    = SRC_K;
                end
                if (cnt_q == CW'(LOAD_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = (nq_q == '0) ? ST_DRAIN : ST_EXEC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_EXEC: begin
                // A stalled cycle issues a bubble and keeps the address for the retry.
                q_addr = aw'(cnt_q);
                if (!stall) begin
                    q_cen = 1'b0;
                    inst  = INST_EXEC;
                    src   = SRC_Q;
                    if (cnt_q == CW'(nq_q - aw'(1))) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Covers 2 pipe stages, col-1 column hops and the last column's write latency.
                if (cnt_q == CW'(col + 2)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    feed_pipe #(
        .bw(bw),
        .pr(pr)
    ) u_pipe (
        .clk_i    (clk),
        .reset_i  (reset),
        .inst_i   (inst),
        .src_i    (src),
        .k_rdata_i(k_rdata),
        .q_rdata_i(q_rdata),
        .inst_o   (o_inst),
        .data_o   (q_out)
    );

endmodule

// File: tb/tb_mac_col_feeder.sv
// tb/tb_mac_col_feeder.sv - randomized model-checked bench for mac_col_feeder, col=8 and col=4 instances
module tb_mac_col_feeder;

    localparam int BW   = 8;
    localparam int PR   = 8;
    localparam int AW   = 6;
    localparam int W    = PR * BW;
    localparam int NG   = 2;
    localparam int NMAX = 128;
    localparam int COL0 = 8;
    localparam int COL1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset [NG];
    logic          start [NG];
    logic [AW-1:0] num_q [NG];
    logic          ofifo_full [NG];
    logic          busy [NG], done [NG], col_reset [NG], k_cen [NG], q_cen [NG];
    logic [AW-1:0] k_addr [NG], q_addr [NG];
    logic [W-1:0]  k_rdata [NG], q_rdata [NG], q_out [NG];
    logic [1:0]    o_inst [NG];

    logic [W-1:0]  kmem [NG][64];
    logic [W-1:0]  qmem [NG][64];

    // Reference trace for one run, indexed by cycles since start was accepted.
    bit            e_kcen [NG][NMAX];
    bit            e_qcen [NG][NMAX];
    logic [AW-1:0] e_kaddr [NG][NMAX];
    logic [AW-1:0] e_qaddr [NG][NMAX];
    logic [1:0]    e_inst [NG][NMAX];
    logic [W-1:0]  e_data [NG][NMAX];
    int            e_t [NG];
    bit            smask [NG][NMAX];
    logic [W-1:0]  m_qout [NG];

    logic [1:0]    d_inst [NG][NMAX];
    logic [W-1:0]  d_q [NG][NMAX];
    int            done_n [NG];

    bit            chk_on [NG];
    bit            run_active [NG];
    bit            post_rst [NG];
    int            cyc_n [NG];
    int            abort_n [NG];

    int            n_vec = 0;
    int            n_err = 0;

    function automatic int col_of(input int g);
        return (g == 0) ? COL0 : COL1;
    endfunction

    generate
        for (genvar g = 0; g < NG; g++) begin : g_dut
            mac_col_feeder #(
                .bw (BW),
                .pr (PR),
                .col((g == 0) ? COL0 : COL1),
                .aw (AW)
            ) dut (
                .clk       (clk),
                .reset     (reset[g]),
                .start     (start[g]),
                .num_q     (num_q[g]),
                .busy      (busy[g]),
                .done      (done[g]),
                .col_reset (col_reset[g]),
                .k_cen     (k_cen[g]),
                .k_addr    (k_addr[g]),
                .k_rdata   (k_rdata[g]),
                .q_cen     (q_cen[g]),
                .q_addr    (q_addr[g]),
                .q_rdata   (q_rdata[g]),
                .o_inst    (o_inst[g]),
                .q_out     (q_out[g])
`ifdef MAC_FEED_BP_EN
                ,
                .ofifo_full(ofifo_full[g])
`endif
            );
        end
    endgenerate

    // SRAM models: one-cycle read latency, garbage on the bus when not enabled.
    always @(posedge clk) begin
        for (int g = 0; g < NG; g++) begin
            k_rdata[g] <= !k_cen[g] ? kmem[g][k_addr[g]] : {$urandom, $urandom};
            q_rdata[g] <= !q_cen[g] ? qmem[g][q_addr[g]] : {$urandom, $urandom};
        end
    end

    task automatic chk(input string nm, input int g, input int n, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d n=%0d got=%h exp=%h", nm, g, n, act, exp);
        end
    endtask

    // Build the expected slot schedule from the run rules: 10 load slots, Q slots skipping stalled cycles, drain, done.
    task automatic build(input int g, input int nq);
        int n;
        int j;
        for (int i = 0; i < NMAX; i++) begin
            e_kcen[g][i]  = 1'b1;
            e_qcen[g][i]  = 1'b1;
            e_kaddr[g][i] = '0;
            e_qaddr[g][i] = '0;
            e_inst[g][i]  = 2'b00;
            e_data[g][i]  = '0;
        end
        for (int k = 0; k < 10; k++) begin
            n = 1 + k;
            e_inst[g][n+2] = 2'b01;
            if (k >= 10 - col_of(g)) begin
                e_kcen[g][n]   = 1'b0;
                e_kaddr[g][n]  = AW'(9 - k);
                e_data[g][n+2] = kmem[g][9-k];
            end
        end
        n = 11;
        j = 0;
        while (j < nq && n < NMAX - 16) begin
            if (!smask[g][n]) begin
                e_qcen[g][n]   = 1'b0;
                e_qaddr[g][n]  = AW'(j);
                e_inst[g][n+2] = 2'b10;
                e_data[g][n+2] = qmem[g][j];
                j++;
            end
            n++;
        end
        e_t[g] = n + col_of(g) + 3;
    endtask

    task automatic run(input int g, input int nq, input bit hold, input int abort_at);
        int guard;
        num_q[g]   = AW'(nq);
        build(g, nq);
        abort_n[g] = abort_at;
        done_n[g]  = -1;
        start[g]   = 1'b1;
        @(posedge clk);
        #1;
        cyc_n[g]      = 0;
        run_active[g] = 1'b1;
        if (!hold) start[g] = 1'b0;
        guard = 0;
        while (run_active[g] && guard < NMAX + 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (run_active[g]) begin
            n_vec++;
            n_err++;
            $display("FAIL run_timeout dut%0d got=busy exp=done", g);
            run_active[g] = 1'b0;
        end
    endtask

    task automatic gap(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_mem(input int g);
        for (int a = 0; a < 64; a++) begin
            kmem[g][a] = {$urandom, $urandom};
            qmem[g][a] = {$urandom, $urandom};
        end
    endtask

    task automatic test_seq(input int g);
        logic [7:0] cb;
        int c;
        c = col_of(g);
        reset[g]      = 1'b1;
        start[g]      = 1'b0;
        num_q[g]      = '0;
        ofifo_full[g] = 1'b0;
        m_qout[g]     = '0;
        for (int i = 0; i < NMAX; i++) smask[g][i] = 1'b0;
        gap(2);
        chk_on[g] = 1'b1;
        gap(2);
        reset[g] = 1'b0;
        gap(2);

        // K[a] = a+1 splat; col c captures key c+1.
        for (int a = 0; a < 64; a++) begin
            cb = 8'(a + 1);
            kmem[g][a] = {PR{cb}};
            qmem[g][a] = {$urandom, $urandom};
        end
        run(g, 4, 1'b0, -1);
        chk("lit_done_nq4", g, 0, W'(done_n[g]), W'(14 + c + 4));
        chk("lit_inst_crst", g, 2, W'(d_inst[g][2]), W'(2'b00));
        chk("lit_inst_lastload", g, 12, W'(d_inst[g][12]), W'(2'b01));
        chk("lit_inst_firstexec", g, 13, W'(d_inst[g][13]), W'(2'b10));
        chk("lit_inst_lastexec", g, 16, W'(d_inst[g][16]), W'(2'b10));
        chk("lit_inst_after", g, 17, W'(d_inst[g][17]), W'(2'b00));
        chk("lit_key_col0", g, 12, d_q[g][12], {PR{8'h01}});
        cb = 8'(c);
        chk("lit_key_lastcol", g, 13 - c, d_q[g][13-c], {PR{cb}});
        if (c < 10) chk("lit_noread_zero", g, 12 - c, d_q[g][12-c], '0);

        gap(2);
        run(g, 0, 1'b0, -1);
        chk("lit_done_nq0", g, 0, W'(done_n[g]), W'(14 + c));

        rand_mem(g);
        for (int r = 0; r < 6; r++) begin
            gap($urandom_range(0, 3));
            run(g, $urandom_range(1, 20), 1'b0, -1);
        end

        // start held across two runs: second run begins only after DONE -> IDLE.
        gap(1);
        run(g, 3, 1'b1, -1);
        run(g, 5, 1'b0, -1);
        gap(3);

        // Abort in EXEC slot 2, then confirm a clean run afterwards.
        run(g, 6, 1'b0, 13);
        gap(3);
        run(g, 2, 1'b0, -1);
        gap(2);

`ifdef MAC_FEED_BP_EN
        smask[g][13] = 1'b1;
        smask[g][14] = 1'b1;
        smask[g][15] = 1'b1;
        run(g, 6, 1'b0, -1);
        chk("lit_done_bp", g, 0, W'(done_n[g]), W'(14 + c + 9));
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NMAX; i++) smask[g][i] = (i >= 11 && i < 60) ? ($urandom_range(0, 3) == 0) : 1'b0;
            gap($urandom_range(0, 2));
            run(g, $urandom_range(1, 16), 1'b0, -1);
        end
        for (int i = 0; i < NMAX; i++) smask[g][i] = 1'b0;
`endif
        gap(4);
    endtask

    // Single compare process: every falling edge, check each instance against its reference.
    initial begin
        int n;
        forever begin
            @(negedge clk);
            for (int g = 0; g < NG; g++) begin
                if (chk_on[g]) begin
                    if (post_rst[g]) begin
                        chk("rst_busy", g, 0, W'(busy[g]), W'(0));
                        chk("rst_done", g, 0, W'(done[g]), W'(0));
                        chk("rst_colreset", g, 0, W'(col_reset[g]), W'(0));
                        chk("rst_kcen", g, 0, W'(k_cen[g]), W'(1));
                        chk("rst_qcen", g, 0, W'(q_cen[g]), W'(1));
                        chk("rst_kaddr", g, 0, W'(k_addr[g]), W'(0));
                        chk("rst_qaddr", g, 0, W'(q_addr[g]), W'(0));
                        chk("rst_inst", g, 0, W'(o_inst[g]), W'(0));
                        chk("rst_qout", g, 0, q_out[g], '0);
                        m_qout[g]   = '0;
                        post_rst[g] = 1'b0;
                        reset[g]    = 1'b0;
                    end else if (run_active[g]) begin
                        n = cyc_n[g];
                        if (e_inst[g][n] != 2'b00) m_qout[g] = e_data[g][n];
                        chk("busy", g, n, W'(busy[g]), W'(1));
                        chk("done", g, n, W'(done[g]), W'(n == e_t[g]));
                        chk("col_reset", g, n, W'(col_reset[g]), W'(n == 0));
                        chk("k_cen", g, n, W'(k_cen[g]), W'(e_kcen[g][n]));
                        if (!e_kcen[g][n]) chk("k_addr", g, n, W'(k_addr[g]), W'(e_kaddr[g][n]));
                        chk("q_cen", g, n, W'(q_cen[g]), W'(e_qcen[g][n]));
                        if (!e_qcen[g][n]) chk("q_addr", g, n, W'(q_addr[g]), W'(e_qaddr[g][n]));
                        chk("o_inst", g, n, W'(o_inst[g]), W'(e_inst[g][n]));
                        chk("q_out", g, n, q_out[g], m_qout[g]);
                        d_inst[g][n] = o_inst[g];
                        d_q[g][n]    = q_out[g];
                        if (done[g] === 1'b1) done_n[g] = n;
                        ofifo_full[g] = smask[g][n+1];
                        if (n == abort_n[g]) begin
                            reset[g]      = 1'b1;
                            run_active[g] = 1'b0;
                            post_rst[g]   = 1'b1;
                        end else if (n >= e_t[g]) begin
                            run_active[g] = 1'b0;
                        end else begin
                            cyc_n[g] = n + 1;
                        end
                    end else begin
                        chk("idle_busy", g, -1, W'(busy[g]), W'(0));
                        chk("idle_done", g, -1, W'(done[g]), W'(0));
                        chk("idle_colreset", g, -1, W'(col_reset[g]), W'(0));
                        chk("idle_kcen", g, -1, W'(k_cen[g]), W'(1));
                        chk("idle_qcen", g, -1, W'(q_cen[g]), W'(1));
                        chk("idle_inst", g, -1, W'(o_inst[g]), W'(0));
                        chk("idle_qout", g, -1, q_out[g], m_qout[g]);
                        ofifo_full[g] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        for (int g = 0; g < NG; g++) begin
            chk_on[g]     = 1'b0;
            run_active[g] = 1'b0;
            post_rst[g]   = 1'b0;
            cyc_n[g]      = 0;
            abort_n[g]    = -1;
            e_t[g]        = 0;
            reset[g]      = 1'b1;
            start[g]      = 1'b0;
            num_q[g]      = '0;
            ofifo_full[g] = 1'b0;
        end
        #1;
        fork
            test_seq(0);
            test_seq(1);
        join
        gap(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
